// File: rtl/body_scan_ctrl.sv
// rtl/body_scan_ctrl.sv - scans snake body-position memory for a segment at a given block
// Optional feature: define BODY_SCAN_EARLY_EXIT_EN to end the scan on the first matching segment.
module body_scan_ctrl #(
  parameter int SNAKE_LENGTH_BIT = 4
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        start,
  input  logic [6:0]                  x_block,
  input  logic [6:0]                  y_block,
  input  logic [3:0]                  snake_length,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  input  logic [6:0]                  snake_body_x,
  input  logic [6:0]                  snake_body_y,
  output logic                        busy,
  output logic                        scan_done,
  output logic                        body_hit,
  output logic [SNAKE_LENGTH_BIT-1:0] hit_index
);

`ifdef BODY_SCAN_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state;
  logic [6:0]                  x_lat;
  logic [6:0]                  y_lat;
  logic [3:0]                  len_lat;
  // rd_valid/rd_index describe which address the memory data on the bus belongs to
  logic                        rd_valid;
  logic [SNAKE_LENGTH_BIT-1:0] rd_index;
  logic                        match;
  logic                        first_hit;
  logic                        at_last;

  // Compare the memory read data against the latched block and detect the last address
  always_comb begin
    match     = rd_valid && (snake_body_x == x_lat) && (snake_body_y == y_lat);
    first_hit = match && !body_hit;
    at_last   = (32'(body_count) + 32'd1) == 32'(len_lat);
  end

  // Scan FSM: issues addresses, tracks the read pipeline and registers every output
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x_lat      <= '0;
      y_lat      <= '0;
      len_lat    <= '0;
      rd_valid   <= 1'b0;
      rd_index   <= '0;
      body_count <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      body_hit   <= 1'b0;
      hit_index  <= '0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_lat     <= x_block;
            y_lat     <= y_block;
            len_lat   <= snake_length;
            busy      <= 1'b1;
            body_hit  <= 1'b0;
            hit_index <= '0;
            rd_valid  <= 1'b0;
            if (snake_length != 4'd0) begin
              state      <= SCAN;
              body_count <= '0;
            end else begin
              state     <= DONE;
              scan_done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (first_hit) begin
            body_hit  <= 1'b1;
            hit_index <= rd_index;
          end
          // the address presented this cycle has its data on the bus next cycle
          rd_valid <= 1'b1;
          rd_index <= body_count;
          if (EARLY_EXIT && first_hit) begin
            state     <= DONE;
            scan_done <= 1'b1;
            rd_valid  <= 1'b0;
          end else if (at_last) begin
            state <= FLUSH;
          end else begin
            body_count <= body_count + SNAKE_LENGTH_BIT'(1);
          end
        end
        FLUSH: begin
          if (first_hit) begin
            body_hit  <= 1'b1;
            hit_index <= rd_index;
          end
          rd_valid  <= 1'b0;
          state     <= DONE;
          scan_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
